// File: rtl/nes_pad_pkg.sv
// Shared types and constants for the NES/SNES multi-pad reader.
package nes_pad_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LATCH = 2'd1,
        READ  = 2'd2,
        DONE  = 2'd3
    } state_e;

    typedef enum logic {
        PH_LOW  = 1'b0,
        PH_HIGH = 1'b1
    } phase_e;

    localparam int unsigned BTN_A      = 0;
    localparam int unsigned BTN_B      = 1;
    localparam int unsigned BTN_SELECT = 2;
    localparam int unsigned BTN_START  = 3;
    localparam int unsigned BTN_UP     = 4;
    localparam int unsigned BTN_DOWN   = 5;
    localparam int unsigned BTN_LEFT   = 6;
    localparam int unsigned BTN_RIGHT  = 7;

    localparam int unsigned NES_BITS    = 8;
    localparam int unsigned SNES_BITS   = 16;
    localparam int unsigned LATCH_TICKS = 2;

    // Counter width able to hold 0..n-1, never narrower than one bit.
    function automatic int unsigned cnt_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/nes_pad_tick.sv
// Free-running clock divider: tick_c is high for one cycle every CLK_DIV cycles.
module nes_pad_tick
    import nes_pad_pkg::*;
#(
    parameter int unsigned CLK_DIV = 150
) (
    input  logic clk,
    input  logic rst_n,
    output logic tick_c
);

    localparam int unsigned DIV_W = cnt_width(CLK_DIV);
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);

    logic [DIV_W-1:0] div_q, div_d;

    assign tick_c = (div_q == DIV_LAST);

    always_comb begin
        div_d = div_q + DIV_W'(1);
        if (tick_c) begin
            div_d = '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            div_q <= '0;
        end else begin
            div_q <= div_d;
        end
    end

endmodule

// File: rtl/nes_pad_multi_reader.sv
// Polls NUM_PADS serial NES/SNES pads on a shared latch/clock and publishes button state.
// Optional NES_PAD_PRESENT_DET_EN adds a per-pad present output and masks absent pads.
module nes_pad_multi_reader
    import nes_pad_pkg::*;
#(
    parameter int unsigned NUM_PADS   = 2,
    parameter int unsigned NUM_BITS   = NES_BITS,
    parameter int unsigned CLK_DIV    = 150,
    parameter int unsigned POLL_TICKS = 2800
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         ena,
    input  logic [NUM_PADS-1:0]          pad_data,
    output logic                         pad_latch,
    output logic                         pad_clk,
    output logic [NUM_PADS*NUM_BITS-1:0] buttons,
    output logic [NUM_PADS*NUM_BITS-1:0] pressed,
    output logic                         valid,
    output logic                         busy
`ifdef NES_PAD_PRESENT_DET_EN
    ,
    output logic [NUM_PADS-1:0]          present
`endif
);

    localparam int unsigned BIT_W  = cnt_width(NUM_BITS);
    localparam int unsigned POLL_W = $clog2(POLL_TICKS + 1);
    localparam int unsigned LCNT_W = cnt_width(LATCH_TICKS);

    localparam logic [BIT_W-1:0]  BIT_LAST   = BIT_W'(NUM_BITS - 1);
    localparam logic [LCNT_W-1:0] LATCH_LAST = LCNT_W'(LATCH_TICKS - 1);
    localparam logic [POLL_W-1:0] POLL_LOAD  = POLL_W'(POLL_TICKS - 1);

    logic tick_c;

    state_e                             state_q, state_d;
    phase_e                             phase_q, phase_d;
    logic [BIT_W-1:0]                   bit_q, bit_d;
    logic [LCNT_W-1:0]                  lcnt_q, lcnt_d;
    logic [POLL_W-1:0]                  poll_cnt_q, poll_cnt_d;
    logic [NUM_PADS-1:0][NUM_BITS-1:0]  shift_q, shift_d;
    logic [NUM_PADS-1:0][NUM_BITS-1:0]  shift_smp, sample_vec;
    logic [NUM_PADS-1:0][NUM_BITS-1:0]  buttons_q, buttons_d;
    logic [NUM_PADS-1:0][NUM_BITS-1:0]  pressed_q, pressed_d;
    logic [NUM_PADS-1:0]                sync1_q, sync2_q;
    logic [NUM_BITS-1:0]                bit_sel;
    logic                               pad_latch_q, pad_latch_d;
    logic                               pad_clk_q, pad_clk_d;
    logic                               valid_q, valid_d;
    logic                               busy_q, busy_d;

    nes_pad_tick #(
        .CLK_DIV (CLK_DIV)
    ) u_tick (
        .clk    (clk),
        .rst_n  (rst_n),
        .tick_c (tick_c)
    );

    assign bit_sel = NUM_BITS'(1) << bit_q;

`ifdef NES_PAD_PRESENT_DET_EN
    logic [NUM_PADS-1:0] present_q, present_d;
    logic [NUM_PADS-1:0] pad_absent;
`endif

    // Per-pad: current shift contents with the synchronised (inverted) bit merged in.
    for (genvar p = 0; p < NUM_PADS; p++) begin : g_pad
        assign shift_smp[p] = (shift_q[p] & ~bit_sel) | ({NUM_BITS{~sync2_q[p]}} & bit_sel);
`ifdef NES_PAD_PRESENT_DET_EN
        // A floating-low data line reads as every button held.
        assign pad_absent[p] = &shift_q[p];
        assign sample_vec[p] = pad_absent[p] ? '0 : shift_q[p];
`else
        assign sample_vec[p] = shift_q[p];
`endif
    end

    // Next-state and registered-output logic.
    always_comb begin
        state_d     = state_q;
        phase_d     = phase_q;
        bit_d       = bit_q;
        lcnt_d      = lcnt_q;
        poll_cnt_d  = poll_cnt_q;
        shift_d     = shift_q;
        pad_latch_d = pad_latch_q;
        pad_clk_d   = pad_clk_q;
        buttons_d   = buttons_q;
        pressed_d   = '0;
        valid_d     = 1'b0;
`ifdef NES_PAD_PRESENT_DET_EN
        present_d   = present_q;
`endif

        unique case (state_q)
            IDLE: begin
                if (tick_c) begin
                    if (poll_cnt_q == '0) begin
                        if (ena) begin
                            state_d     = LATCH;
                            pad_latch_d = 1'b1;
                            lcnt_d      = '0;
                        end
                    end else begin
                        poll_cnt_d = poll_cnt_q - POLL_W'(1);
                    end
                end
            end
            LATCH: begin
                if (tick_c) begin
                    if (lcnt_q == LATCH_LAST) begin
                        state_d     = READ;
                        pad_latch_d = 1'b0;
                        bit_d       = '0;
                        phase_d     = PH_LOW;
                    end else begin
                        lcnt_d = lcnt_q + LCNT_W'(1);
                    end
                end
            end
            READ: begin
                if (tick_c) begin
                    if (phase_q == PH_LOW) begin
                        shift_d = shift_smp;
                        if (bit_q == BIT_LAST) begin
                            state_d = DONE;
                        end else begin
                            pad_clk_d = 1'b1;
                            phase_d   = PH_HIGH;
                        end
                    end else begin
                        pad_clk_d = 1'b0;
                        bit_d     = bit_q + BIT_W'(1);
                        phase_d   = PH_LOW;
                    end
                end
            end
            DONE: begin
                buttons_d  = sample_vec;
                pressed_d  = sample_vec & ~buttons_q;
                valid_d    = 1'b1;
                poll_cnt_d = POLL_LOAD;
                state_d    = IDLE;
`ifdef NES_PAD_PRESENT_DET_EN
                present_d  = ~pad_absent;
`endif
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        busy_d = (state_d == LATCH) || (state_d == READ);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            phase_q     <= PH_LOW;
            bit_q       <= '0;
            lcnt_q      <= '0;
            poll_cnt_q  <= '0;
            shift_q     <= '0;
            buttons_q   <= '0;
            pressed_q   <= '0;
            sync1_q     <= '0;
            sync2_q     <= '0;
            pad_latch_q <= 1'b0;
            pad_clk_q   <= 1'b0;
            valid_q     <= 1'b0;
            busy_q      <= 1'b0;
`ifdef NES_PAD_PRESENT_DET_EN
            present_q   <= '0;
`endif
        end else begin
            state_q     <= state_d;
            phase_q     <= phase_d;
            bit_q       <= bit_d;
            lcnt_q      <= lcnt_d;
            poll_cnt_q  <= poll_cnt_d;
            shift_q     <= shift_d;
            buttons_q   <= buttons_d;
            pressed_q   <= pressed_d;
            sync1_q     <= pad_data;
            sync2_q     <= sync1_q;
            pad_latch_q <= pad_latch_d;
            pad_clk_q   <= pad_clk_d;
            valid_q     <= valid_d;
            busy_q      <= busy_d;
`ifdef NES_PAD_PRESENT_DET_EN
            present_q   <= present_d;
`endif
        end
    end

    assign pad_latch = pad_latch_q;
    assign pad_clk   = pad_clk_q;
    assign buttons   = buttons_q;
    assign pressed   = pressed_q;
    assign valid     = valid_q;
    assign busy      = busy_q;
`ifdef NES_PAD_PRESENT_DET_EN
    assign present   = present_q;
`endif

endmodule

// File: tb/tb_nes_pad_multi_reader.sv
// Scoreboard bench for nes_pad_multi_reader: shift-register pad models, reference queue, monitors.
// Builds with or without NES_PAD_PRESENT_DET_EN.
module tb_nes_pad_multi_reader;
    import nes_pad_pkg::*;

    localparam int unsigned NP  = 2;
    localparam int unsigned NB  = 8;
    localparam int unsigned CD  = 4;
    localparam int unsigned PT  = 10;
    localparam int unsigned SNB = 16;
    localparam int unsigned W   = NP * NB;

    logic          clk   = 1'b0;
    logic          rst_n = 1'b1;
    logic          ena   = 1'b1;
    logic [NP-1:0] pad_data;
    logic          pad_latch, pad_clk, valid, busy;
    logic [W-1:0]  buttons, pressed;
    logic          s_latch, s_pclk, s_valid, s_busy;
    logic [SNB-1:0] s_buttons, s_pressed;
`ifdef NES_PAD_PRESENT_DET_EN
    logic [NP-1:0] present;
    logic          s_present;
`endif

    always #5 clk = ~clk;

    nes_pad_multi_reader #(
        .NUM_PADS(NP), .NUM_BITS(NB), .CLK_DIV(CD), .POLL_TICKS(PT)
    ) dut (
        .clk(clk), .rst_n(rst_n), .ena(ena), .pad_data(pad_data),
        .pad_latch(pad_latch), .pad_clk(pad_clk), .buttons(buttons),
        .pressed(pressed), .valid(valid), .busy(busy)
`ifdef NES_PAD_PRESENT_DET_EN
        , .present(present)
`endif
    );

    // SNES-width instance with one released pad, used for clock pulse counting.
    nes_pad_multi_reader #(
        .NUM_PADS(1), .NUM_BITS(SNB), .CLK_DIV(CD), .POLL_TICKS(PT)
    ) dut_snes (
        .clk(clk), .rst_n(rst_n), .ena(ena), .pad_data(1'b1),
        .pad_latch(s_latch), .pad_clk(s_pclk), .buttons(s_buttons),
        .pressed(s_pressed), .valid(s_valid), .busy(s_busy)
`ifdef NES_PAD_PRESENT_DET_EN
        , .present(s_present)
`endif
    );

    typedef struct packed {
        logic [W-1:0]  b;
        logic [W-1:0]  pr;
        logic [NP-1:0] pres;
    } exp_t;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Pad model: pressed-bit vectors, absent flag, and a 4021-style shift register.
    logic [NB-1:0] btn [NP];
    logic [NB-1:0] sh  [NP];
    bit            absent [NP];
    exp_t          sbq[$];
    logic [W-1:0]  prev_b = '0;
    int            valid_cnt = 0;
    int            latch_rises = 0;
    int            s_pulses = 0;

    initial begin
        for (int p = 0; p < NP; p++) begin
            btn[p] = '0; sh[p] = '0; absent[p] = 1'b0;
        end
    end

    always_comb begin
        for (int p = 0; p < NP; p++) pad_data[p] = ~sh[p][0];
    end

    always @(posedge pad_clk) begin
        for (int p = 0; p < NP; p++) sh[p] = sh[p] >> 1;
    end

    always @(posedge pad_latch) latch_rises++;

    // Snapshot at latch release: the pads freeze their buttons and the expected result is queued.
    always @(negedge pad_latch) begin : sb_push
        exp_t e;
        logic [NB-1:0] s;
        if (rst_n) begin
            e = '0;
            for (int p = 0; p < NP; p++) begin
                s = absent[p] ? '1 : btn[p];
                sh[p] = s;
                e.pres[p] = 1'b1;
`ifdef NES_PAD_PRESENT_DET_EN
                if (s == '1) begin
                    e.pres[p] = 1'b0;
                    s = '0;
                end
`endif
                e.b[p*NB +: NB] = s;
            end
            e.pr   = e.b & ~prev_b;
            prev_b = e.b;
            sbq.push_back(e);
        end
    end

    // Monitor: every valid pulse is matched against the oldest queued expectation.
    always @(negedge clk) begin : mon
        exp_t e;
        if (rst_n && valid) begin
            valid_cnt++;
            if (sbq.size() == 0) begin
                check("valid_without_poll", 32'(valid), 32'd0);
            end else begin
                e = sbq.pop_front();
                check("buttons", 32'(buttons), 32'(e.b));
                check("pressed", 32'(pressed), 32'(e.pr));
`ifdef NES_PAD_PRESENT_DET_EN
                check("present", 32'(present), 32'(e.pres));
`endif
            end
        end
        if (rst_n && s_valid) begin
            check("snes_clk_pulses", 32'(s_pulses), 32'(SNB - 1));
            check("snes_buttons", 32'(s_buttons), 32'd0);
        end
    end

    always @(posedge s_latch) s_pulses = 0;
    always @(posedge s_pclk)  s_pulses++;

    task automatic check_reset_outputs();
        check("rst_pad_latch", 32'(pad_latch), 32'd0);
        check("rst_pad_clk",   32'(pad_clk),   32'd0);
        check("rst_buttons",   32'(buttons),   32'd0);
        check("rst_pressed",   32'(pressed),   32'd0);
        check("rst_valid",     32'(valid),     32'd0);
        check("rst_busy",      32'(busy),      32'd0);
`ifdef NES_PAD_PRESENT_DET_EN
        check("rst_present",   32'(present),   32'd0);
`endif
    endtask

    task automatic apply_reset();
        @(negedge clk);
        rst_n = 1'b0;
        sbq.delete();
        prev_b = '0;
        repeat (3) @(negedge clk);
        check_reset_outputs();
        rst_n = 1'b1;
    endtask

    task automatic wait_valid(input string name);
        int n;
        n = 0;
        do begin
            @(posedge clk); #1; n++;
        end while (!valid && n < 2000);
        check({name, "_timeout"}, 32'(n < 2000), 32'd1);
    endtask

    // Cycle-level check of the first poll after reset release.
    task automatic check_first_poll();
        int n, hi, pulses, w, guard;
        bit width_ok;
        n = 0;
        while (!pad_latch && n < 200) begin @(posedge clk); #1; n++; end
        check("latch_rise_cycle", 32'(n), 32'(CD));
        hi = 0;
        while (pad_latch && hi < 200) begin @(posedge clk); #1; hi++; end
        check("latch_high_cycles", 32'(hi), 32'(LATCH_TICKS * CD));
        pulses = 0; width_ok = 1'b1; guard = 0;
        while (!valid && guard < 2000) begin
            if (pad_clk) begin
                w = 0;
                while (pad_clk && w < 200) begin @(posedge clk); #1; w++; guard++; end
                pulses++;
                if (w != CD) width_ok = 1'b0;
            end else begin
                @(posedge clk); #1; guard++;
            end
        end
        check("first_valid_timeout", 32'(guard < 2000), 32'd1);
        check("pad_clk_pulses", 32'(pulses), 32'(NB - 1));
        check("pad_clk_width", 32'(width_ok), 32'd1);
        check("first_buttons", 32'(buttons), 32'h0081);
        check("first_pressed", 32'(pressed), 32'h0081);
    endtask

    initial begin : watchdog
        #600000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin : stim
        int n, falls, v0, l0;
        bit prev_clk;
        btn[0] = NB'((1 << BTN_A) | (1 << BTN_RIGHT));
        btn[1] = '0;
        #1 rst_n = 1'b0;
        apply_reset();
        check_first_poll();

        // Same pattern: held but not newly pressed; then release A.
        wait_valid("repeat_poll");
        check("repeat_buttons", 32'(buttons), 32'h0081);
        check("repeat_pressed", 32'(pressed), 32'h0000);
        btn[0] = NB'(1 << BTN_RIGHT);
        wait_valid("release_poll");
        check("release_buttons", 32'(buttons), 32'h0080);
        check("release_pressed", 32'(pressed), 32'h0000);

        // Asynchronous reset while shifting bit 3.
        falls = 0; n = 0; prev_clk = pad_clk;
        while (falls < 3 && n < 2000) begin
            @(posedge clk); #1; n++;
            if (prev_clk && !pad_clk) falls++;
            prev_clk = pad_clk;
        end
        while (!pad_clk && n < 2000) begin @(posedge clk); #1; n++; end
        check("reach_bit3", 32'(n < 2000), 32'd1);
        check("busy_in_read", 32'(busy), 32'd1);
        #2 rst_n = 1'b0;
        sbq.delete();
        prev_b = '0;
        #1;
        check("midrst_pad_clk",   32'(pad_clk),   32'd0);
        check("midrst_pad_latch", 32'(pad_latch), 32'd0);
        check("midrst_buttons",   32'(buttons),   32'd0);
        check("midrst_busy",      32'(busy),      32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        wait_valid("post_reset_poll");
        check("clean_buttons", 32'(buttons), 32'h0080);
        check("clean_pressed", 32'(pressed), 32'h0080);

        // Enable low from reset: no poll at all, then starts on the next tick.
        ena = 1'b0;
        apply_reset();
        v0 = valid_cnt; l0 = latch_rises;
        repeat (400) @(negedge clk);
        check("ena0_no_latch", 32'(latch_rises - l0), 32'd0);
        check("ena0_no_valid", 32'(valid_cnt - v0), 32'd0);
        ena = 1'b1;
        n = 0;
        while (!pad_latch && n < 200) begin @(posedge clk); #1; n++; end
        check("ena1_latch_within_tick", 32'(n >= 1 && n <= CD), 32'd1);
        wait_valid("ena1_poll");

        // Enable dropped mid-poll: that poll still completes.
        n = 0;
        while (!pad_latch && n < 2000) begin @(posedge clk); #1; n++; end
        ena = 1'b0;
        wait_valid("ena_drop_poll");
        ena = 1'b1;

        // Randomised button changes, absent toggling and enable gaps.
        for (int i = 0; i < 30; i++) begin
            repeat ($urandom_range(20, 140)) @(negedge clk);
            for (int p = 0; p < NP; p++) begin
                case ($urandom_range(0, 3))
                    0: ;
                    1: btn[p] = '0;
                    default: btn[p] = NB'($urandom);
                endcase
            end
            if ($urandom_range(0, 7) == 0) absent[1] = ~absent[1];
            ena = ($urandom_range(0, 5) != 0);
        end
        ena = 1'b1;
        absent[1] = 1'b0;

        // Pad 1 line stuck low.
        wait_valid("pre_absent");
        absent[1] = 1'b1;
        btn[0] = NB'(1 << BTN_A);
        wait_valid("absent_poll_a");
        wait_valid("absent_poll_b");
`ifdef NES_PAD_PRESENT_DET_EN
        check("absent_present", 32'(present), 32'b01);
        check("absent_hi_buttons", 32'(buttons[W-1:NB]), 32'h00);
`else
        check("absent_hi_buttons", 32'(buttons[W-1:NB]), 32'hFF);
`endif
        check("absent_lo_buttons", 32'(buttons[NB-1:0]), 32'h01);

        ena = 1'b0;
        repeat (300) @(negedge clk);
        check("scoreboard_drained", 32'(sbq.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
